disp_scan: RTL
==============

# disp_scan

Time-multiplexed driver for a bank of common-anode-selected 7-segment digits. Holds a shadow copy of DIGITS packed 4-bit codes with per-digit decimal-point and blank flags, and cycles one active digit at a time at a programmable scan rate. Each selected code is decoded into the team's segment format: seg[7:1] = a..g, seg[0] = dp, active-high. It sits between the game/counter logic and the board's segment/digit pins, and replaces the single-digit combinational decoder.

## Interface
- DIGITS, 8, number of multiplexed digits; legal range 1..16.
- SCAN_DIV, 50000, clk cycles each digit stays active; legal range ≥1.
- clk  input  1  system clock; all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- st  input  1  scan enable; 0 blanks the display and parks the scanner at digit 0.
- ld  input  1  shadow load strobe; samples num/dp/blk on this edge.
- num  input  4*DIGITS  packed codes; digit i is num[4i+3:4i].
- dp  input  DIGITS  decimal point per digit; 1 lights the point.
- blk  input  DIGITS  per-digit blank; 1 forces that digit dark.
- seg  output  8  registered segment pattern {a,b,c,d,e,f,g,dp}, active-high.
- dig  output  DIGITS  registered digit select, active-low one-cold.

## Operation
- Shadow registers: sh_num, sh_dp and sh_blk load from num, dp and blk on any edge with ld=1, regardless of st. Otherwise they hold.
- Prescaler cnt and index idx:
  - While st=1: if cnt==SCAN_DIV-1, then cnt←0 and idx advances; otherwise cnt←cnt+1.
  - idx advances 0→1→…→DIGITS-1→0. It wraps exactly at DIGITS, not at a power of two.
- Output register on an edge with st=1:
  - seg ← glyph(sh_num[idx]) with bit0 = sh_dp[idx]. If sh_blk[idx]=1, seg ← 8'h00, including dp.
  - dig ← all ones except bit idx = 0. dig still selects the digit when it is blanked.
  - Both use pre-edge idx and shadow values.
- On an edge with st=0: cnt←0, idx←0, seg←8'h00, dig←all ones.
- Glyphs:
  - 0–9: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6 (hex, dp bit clear).
  - Codes 10–15 depend on the configuration (see below).
- Widths:
  - cnt is max(1,$clog2(SCAN_DIV)) bits; idx is max(1,$clog2(DIGITS)) bits.
  - If DIGITS=1, idx stays at 0 permanently.
  - If SCAN_DIV=1, idx advances every cycle.

## Timing
- Reset (asynchronous, immediate) values: seg=8'h00, dig=all ones, cnt=0, idx=0, sh_num=0, sh_dp=0, sh_blk=0.
- Latency: a change in idx or in the shadow appears on seg/dig one edge later.
- Dwell time:
  - With st held high, each digit is active for exactly SCAN_DIV consecutive cycles.
  - A full frame is DIGITS*SCAN_DIV cycles.
  - The first active output, digit 0, appears on the first edge at which st is sampled high.
- ld on the same edge as a digit advance: the new shadow value first affects the output on the following edge.
- st dropping mid-frame: the display goes blank on the next edge. When st is raised again, scanning restarts at digit 0 with a full SCAN_DIV dwell.
- rst asserted mid-scan: all state clears immediately, with no partial digit hold.

## Configuration
- DISP_HEX_EN defined: codes 10–15 decode to A=EE, b=3E, C=9C, d=7A, E=9E, F=8E.
- DISP_HEX_EN undefined: codes 10–15 decode to 8'h00. dp and the digit select still follow their normal rules.

## Structure
- Package disp_pkg holds:
  - 8-bit glyph constants GLYPH_0..GLYPH_F and SEG_BLANK = 8'h00.
  - The segment-bit ordering constants.
- Sub-module disp_seg_dec: combinational 4-bit-to-7-segment decoder.
  - It is the only place DISP_HEX_EN is tested.
  - disp_scan instantiates it once, on the muxed sh_num[idx].

## Test plan
- Reset release, st=0 for 20 cycles -> seg=00 and dig=all ones throughout. All internal counters at 0.
- DIGITS=4, SCAN_DIV=3, ld with num=16'h4321, st=1 -> dig sequence E,D,B,7 (3 cycles each) with seg 60,DA,F2,66, then wraps to E.
- Same config, st dropped during digit 2, raised 5 cycles later -> blank on the next edge, then restart at dig=E for 3 cycles.
- dp=4'b0100, blk=4'b0001 loaded -> digit 0 shows seg=00 with dig=E; digit 2 shows F3 (F2 with dp set).
- num digit = 4'hA: with DISP_HEX_EN -> seg=EE; without it -> seg=00.
- DIGITS=1, SCAN_DIV=1, ld mid-scan -> dig stays 0, and seg changes exactly one edge after the ld edge.

Source files
------------

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared glyph and segment-ordering constants for the digit scanner
//
// Purpose: one home for the 7-segment glyph table and the segment bit layout.
// Segment format, active-high: seg[7:1] = a..g, seg[0] = dp.
// Glyph constants always carry dp = 0. The scanner ORs in the decimal point separately.
// The hex glyphs A..F are always defined here.
// Whether the decoder uses them is decided in disp_seg_dec (DISP_HEX_EN).

package disp_pkg;

  // segment bit positions within seg[7:0]
  localparam int SEG_BIT_A  = 7;
  localparam int SEG_BIT_B  = 6;
  localparam int SEG_BIT_C  = 5;
  localparam int SEG_BIT_D  = 4;
  localparam int SEG_BIT_E  = 3;
  localparam int SEG_BIT_F  = 2;
  localparam int SEG_BIT_G  = 1;
  localparam int SEG_BIT_DP = 0;

  localparam logic [7:0] SEG_BLANK   = 8'h00;
  localparam logic [7:0] SEG_DP_MASK = 8'h01 << SEG_BIT_DP;

  // decimal glyphs
  localparam logic [7:0] GLYPH_0 = 8'hFC;
  localparam logic [7:0] GLYPH_1 = 8'h60;
  localparam logic [7:0] GLYPH_2 = 8'hDA;
  localparam logic [7:0] GLYPH_3 = 8'hF2;
  localparam logic [7:0] GLYPH_4 = 8'h66;
  localparam logic [7:0] GLYPH_5 = 8'hB6;
  localparam logic [7:0] GLYPH_6 = 8'hBE;
  localparam logic [7:0] GLYPH_7 = 8'hE0;
  localparam logic [7:0] GLYPH_8 = 8'hFE;
  localparam logic [7:0] GLYPH_9 = 8'hF6;

  // hex glyphs: A, b, C, d, E, F
  localparam logic [7:0] GLYPH_A = 8'hEE;
  localparam logic [7:0] GLYPH_B = 8'h3E;
  localparam logic [7:0] GLYPH_C = 8'h9C;
  localparam logic [7:0] GLYPH_D = 8'h7A;
  localparam logic [7:0] GLYPH_E = 8'h9E;
  localparam logic [7:0] GLYPH_F = 8'h8E;

endpackage

// File: rtl/disp_seg_dec.sv
// rtl/disp_seg_dec.sv - combinational 4-bit code to 7-segment glyph decoder
//
// Purpose: maps one 4-bit code to its segment pattern. The dp bit of the result is always clear.
// Configuration macro: DISP_HEX_EN.
//   defined   - codes 10..15 show A, b, C, d, E, F
//   undefined - codes 10..15 decode dark (all segments off)
// Ports:
//   code   in  4  code to display
//   glyph  out 8  {a,b,c,d,e,f,g,dp}, active-high, dp = 0

import disp_pkg::*;

module disp_seg_dec (
  input  logic [3:0] code,
  output logic [7:0] glyph
);

  always_comb begin
    glyph = SEG_BLANK;
    case (code)
      4'd0:  glyph = GLYPH_0;
      4'd1:  glyph = GLYPH_1;
      4'd2:  glyph = GLYPH_2;
      4'd3:  glyph = GLYPH_3;
      4'd4:  glyph = GLYPH_4;
      4'd5:  glyph = GLYPH_5;
      4'd6:  glyph = GLYPH_6;
      4'd7:  glyph = GLYPH_7;
      4'd8:  glyph = GLYPH_8;
      4'd9:  glyph = GLYPH_9;
`ifdef DISP_HEX_EN
      4'd10: glyph = GLYPH_A;
      4'd11: glyph = GLYPH_B;
      4'd12: glyph = GLYPH_C;
      4'd13: glyph = GLYPH_D;
      4'd14: glyph = GLYPH_E;
      4'd15: glyph = GLYPH_F;
`else
      default: glyph = SEG_BLANK;
`endif
    endcase
  end

endmodule

// File: rtl/disp_scan.sv
// rtl/disp_scan.sv - time-multiplexed 7-segment scanner with shadow registers
//
// Purpose: holds a shadow copy of DIGITS codes and their dp/blank flags.
// It lights one digit at a time, and each digit stays active for SCAN_DIV clocks.
// Configuration macro: DISP_HEX_EN, passed through to disp_seg_dec (hex glyphs for codes 10..15).
// Ports:
//   clk  in  1          rising-edge clock
//   rst  in  1          asynchronous active-high reset
//   st   in  1          scan enable; 0 blanks and parks the scanner on digit 0
//   ld   in  1          shadow load strobe for num/dp/blk
//   num  in  4*DIGITS   packed codes, digit i = num[4i+3:4i]
//   dp   in  DIGITS     decimal point per digit
//   blk  in  DIGITS     blank per digit
//   seg  out 8          registered {a..g,dp}, active-high
//   dig  out DIGITS     registered digit select, active-low one-cold

import disp_pkg::*;

module disp_scan #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st,
  input  logic                  ld,
  input  logic [4*DIGITS-1:0]   num,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blk,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // terminal values; the index wraps at DIGITS, not at a power of two
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [4*DIGITS-1:0] sh_num;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   sh_blk;

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;

  logic [3:0]          cur_code;
  logic                cur_dp;
  logic                cur_blk;
  logic [DIGITS-1:0]   cur_sel_n;
  logic [7:0]          cur_glyph;
  logic [7:0]          seg_nx;

  // Select the active digit from the shadow copy.
  // The loop compare keeps the mux legal for any DIGITS, including 1.
  always_comb begin
    cur_code  = 4'h0;
    cur_dp    = 1'b0;
    cur_blk   = 1'b0;
    cur_sel_n = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_code     = sh_num[4*i +: 4];
        cur_dp       = sh_dp[i];
        cur_blk      = sh_blk[i];
        cur_sel_n[i] = 1'b0;
      end
    end
  end

  disp_seg_dec u_dec (
    .code  (cur_code),
    .glyph (cur_glyph)
  );

  // A blanked digit is fully dark, dp included. Its select line still drives the digit.
  always_comb begin
    seg_nx = SEG_BLANK;
    if (!cur_blk)
      seg_nx = cur_glyph | (cur_dp ? SEG_DP_MASK : SEG_BLANK);
  end

  // shadow registers: load whenever ld is high, independent of st
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_num <= '0;
      sh_dp  <= '0;
      sh_blk <= '0;
    end else if (ld) begin
      sh_num <= num;
      sh_dp  <= dp;
      sh_blk <= blk;
    end
  end

  // Prescaler, digit index and registered outputs.
  // The outputs are built from the pre-edge idx and shadow values.
  // A new index or a new shadow value therefore appears one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      seg <= SEG_BLANK;
      dig <= '1;
    end else if (!st) begin
      cnt <= '0;
      idx <= '0;
      seg <= SEG_BLANK;
      dig <= '1;
    end else begin
      seg <= seg_nx;
      dig <= cur_sel_n;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
